// File: rtl/fetch_decode_ctrl_if.sv
// Fetch/decode control bus: instruction-memory handshake, next-PC input,
// stall input and the decoded instruction fields.
interface fetch_decode_ctrl_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned BRW  = 4;
  localparam int unsigned SELW = 2;
  localparam int unsigned BLW  = 16;
  localparam int unsigned JLW  = 26;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] next_pc;
  logic            stall;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic [BRW-1:0]  brtype;
  logic [SELW-1:0] pc_sel;
  logic [BLW-1:0]  branch_label;
  logic [JLW-1:0]  jmp_label;
  logic            fetch_err;

  // Controller side
  modport master (
    output imem_req, imem_addr, pc, instr, instr_valid, brtype, pc_sel,
           branch_label, jmp_label, fetch_err,
    input  imem_ack, imem_rdata, next_pc, stall
  );

  // Memory / next-address / downstream side
  modport slave (
    input  imem_req, imem_addr, pc, instr, instr_valid, brtype, pc_sel,
           branch_label, jmp_label, fetch_err,
    output imem_ack, imem_rdata, next_pc, stall
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode controller: fetches one instruction word at pc, decodes the
// branch/jump fields, holds them while stalled, then loads pc from next_pc.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch timeout, error pulse, retry).
module fetch_decode_ctrl (
  input logic                  clk,
  input logic                  reset,
  fetch_decode_ctrl_if.master  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;
  localparam int unsigned BRW  = 4;
  localparam int unsigned SELW = 2;
  localparam int unsigned BLW  = 16;
  localparam int unsigned JLW  = 26;

  localparam logic [OPW-1:0]  OP_BR_LO = 6'h10;
  localparam logic [OPW-1:0]  OP_BR_HI = 6'h18;
  localparam logic [OPW-1:0]  OP_JMP   = 6'h20;
  localparam logic [OPW-1:0]  OP_JR    = 6'h21;
  localparam logic [SELW-1:0] SEL_SEQ  = 2'd0;
  localparam logic [SELW-1:0] SEL_JMP  = 2'd1;
  localparam logic [SELW-1:0] SEL_REG  = 2'd2;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, HOLD, UPDATE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [BRW-1:0]  brtype_q, brtype_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [BLW-1:0]  blabel_q, blabel_d;
  logic [JLW-1:0]  jlabel_q, jlabel_d;
  logic            req_q, req_d;
  logic [OPW-1:0]  opcode;

  assign opcode = instr_q[XLEN-1 -: OPW];

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TOW      = 4;
  localparam int unsigned TO_LIMIT = 15;

  logic [TOW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           timeout;

  // Count about to reach the limit on this un-acked fetch cycle
  assign timeout = (cnt_q == TOW'(TO_LIMIT - 1));
`endif

  // Next-state and next-output computation
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    brtype_d = brtype_q;
    sel_d    = sel_q;
    blabel_d = blabel_q;
    jlabel_d = jlabel_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = DECODE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      DECODE: begin
        brtype_d = '0;
        blabel_d = '0;
        jlabel_d = '0;
        sel_d    = SEL_SEQ;
        if (opcode >= OP_BR_LO && opcode <= OP_BR_HI) begin
          brtype_d = opcode[BRW-1:0];
          blabel_d = instr_q[BLW-1:0];
        end else if (opcode == OP_JMP) begin
          sel_d    = SEL_JMP;
          jlabel_d = instr_q[JLW-1:0];
        end else if (opcode == OP_JR) begin
          sel_d    = SEL_REG;
        end
        state_d = HOLD;
      end
      HOLD: if (!bus.stall) state_d = UPDATE;
      UPDATE: begin
        pc_d    = bus.next_pc;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    req_d   = (state_d == FETCH);
    valid_d = (state_d == HOLD);

`ifdef FETCH_TIMEOUT_EN
    if (state_d == FETCH && state_q != FETCH) begin
      cnt_d = '0;
    end else if (state_q == FETCH && !bus.imem_ack) begin
      cnt_d = cnt_q + TOW'(1);
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      brtype_q <= '0;
      sel_q    <= SEL_SEQ;
      blabel_q <= '0;
      jlabel_q <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      brtype_q <= brtype_d;
      sel_q    <= sel_d;
      blabel_q <= blabel_d;
      jlabel_q <= jlabel_d;
      req_q    <= req_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Timeout counter and error pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.fetch_err = err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.imem_req     = req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.instr        = instr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.brtype       = brtype_q;
  assign bus.pc_sel       = sel_q;
  assign bus.branch_label = blabel_q;
  assign bus.jmp_label    = jlabel_q;
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl; FETCH_TIMEOUT_EN selects the
// timeout scenario instead of the wait-forever scenario.
module tb_fetch_decode_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fetch_decode_ctrl_if bus ();

  fetch_decode_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Present one instruction word in the current FETCH cycle; ends in HOLD
  task automatic fetch_one(input logic [31:0] word);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [114:0] outs;
    reset = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    outs = {bus.pc, bus.instr, bus.instr_valid, bus.brtype, bus.pc_sel,
            bus.branch_label, bus.jmp_label, bus.imem_req, bus.fetch_err};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_req: got %b expected 1", bus.imem_req);
    end
    n_checks++;
    if (bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_addr: got %h expected 0", bus.imem_addr);
    end
  endtask

  task automatic test_sequential();
    bus.next_pc = 32'h1;
    fetch_one(32'h0000_0000);
    n_checks++;
    if ({bus.instr_valid, bus.brtype, bus.pc_sel} !== 7'b1_0000_00) begin
      n_fail++;
      $display("FAIL seq_decode: got valid=%b brtype=%h sel=%h expected 1/0/0",
               bus.instr_valid, bus.brtype, bus.pc_sel);
    end
    n_checks++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_req_hold: got %b expected 0", bus.imem_req);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.instr_valid, bus.pc} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL seq_update: got valid=%b pc=%h expected 0/0",
               bus.instr_valid, bus.pc);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.pc, bus.imem_addr} !== {1'b1, 32'h1, 32'h1}) begin
      n_fail++;
      $display("FAIL seq_next_fetch: got req=%b pc=%h addr=%h expected 1/1/1",
               bus.imem_req, bus.pc, bus.imem_addr);
    end
  endtask

  task automatic test_branch();
    logic [31:0] words  [4];
    logic [3:0]  exp_br [4];
    logic [15:0] exp_lb [4];
    words[0] = 32'h4400_FFFE; exp_br[0] = 4'd1; exp_lb[0] = 16'hFFFE;
    words[1] = 32'h4000_0005; exp_br[1] = 4'd0; exp_lb[1] = 16'h0005;
    words[2] = 32'h6000_1234; exp_br[2] = 4'd8; exp_lb[2] = 16'h1234;
    words[3] = 32'h6400_1234; exp_br[3] = 4'd0; exp_lb[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      bus.next_pc = 32'(2 + i);
      fetch_one(words[i]);
      n_checks++;
      if ({bus.brtype, bus.branch_label, bus.pc_sel} !== {exp_br[i], exp_lb[i], 2'd0}) begin
        n_fail++;
        $display("FAIL branch_decode[%0d]: got brtype=%h label=%h sel=%h expected %h/%h/0",
                 i, bus.brtype, bus.branch_label, bus.pc_sel, exp_br[i], exp_lb[i]);
      end
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.pc !== 32'(2 + i)) begin
        n_fail++;
        $display("FAIL branch_pc[%0d]: got %h expected %h", i, bus.pc, 32'(2 + i));
      end
    end
  endtask

  task automatic test_jump();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h5}) begin
      n_fail++;
      $display("FAIL jump_wait_ack: got req=%b addr=%h expected 1/5",
               bus.imem_req, bus.imem_addr);
    end
    bus.next_pc = 32'h20;
    fetch_one(32'h8000_0040);
    n_checks++;
    if ({bus.pc_sel, bus.jmp_label, bus.brtype, bus.branch_label} !==
        {2'd1, 26'h000_0040, 4'd0, 16'h0}) begin
      n_fail++;
      $display("FAIL jump_decode: got sel=%h jmp=%h brtype=%h label=%h expected 1/40/0/0",
               bus.pc_sel, bus.jmp_label, bus.brtype, bus.branch_label);
    end
    @(negedge clk);
    @(negedge clk);
    bus.next_pc = 32'hFFFF_FFFF;
    fetch_one(32'h8400_0000);
    n_checks++;
    if (bus.pc_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL jr_decode: got sel=%h expected 2", bus.pc_sel);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    n_checks++;
    if ({bus.instr, bus.imem_req} !== {32'h8400_0000, 1'b0}) begin
      n_fail++;
      $display("FAIL ack_ignored: got instr=%h req=%b expected 84000000/0",
               bus.instr, bus.imem_req);
    end
    @(negedge clk);
    n_checks++;
    if (bus.pc !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL full_pc_load: got %h expected ffffffff", bus.pc);
    end
  endtask

  task automatic test_stall();
    bus.stall   = 1'b1;
    bus.next_pc = 32'h10;
    fetch_one(32'h4400_FFFE);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus.instr_valid, bus.brtype, bus.branch_label, bus.pc} !==
          {1'b1, 4'd1, 16'hFFFE, 32'hFFFF_FFFF}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b brtype=%h label=%h pc=%h expected 1/1/fffe/ffffffff",
                 i, bus.instr_valid, bus.brtype, bus.branch_label, bus.pc);
      end
      @(negedge clk);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.instr_valid, bus.pc} !== {1'b0, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b pc=%h expected 0/ffffffff",
               bus.instr_valid, bus.pc);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h10}) begin
      n_fail++;
      $display("FAIL stall_next_fetch: got req=%b addr=%h expected 1/10",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [114:0] outs;
    #2 reset = 1'b1;
    #1;
    outs = {bus.pc, bus.instr, bus.instr_valid, bus.brtype, bus.pc_sel,
            bus.branch_label, bus.jmp_label, bus.imem_req, bus.fetch_err};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_fetch: got %h expected 0", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL refetch_addr0: got req=%b addr=%h expected 1/0",
               bus.imem_req, bus.imem_addr);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if ({bus.imem_req, bus.fetch_err} !== 2'b10) begin
        n_fail++;
        $display("FAIL timeout_wait[%0d]: got req=%b err=%b expected 1/0",
                 i, bus.imem_req, bus.fetch_err);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({bus.imem_req, bus.fetch_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_pulse: got req=%b err=%b expected 0/1",
               bus.imem_req, bus.fetch_err);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.fetch_err, bus.imem_addr} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_retry: got req=%b err=%b addr=%h expected 1/0/0",
               bus.imem_req, bus.fetch_err, bus.imem_addr);
    end
    repeat (14) @(negedge clk);
    fetch_one(32'h8400_0000);
    n_checks++;
    if ({bus.fetch_err, bus.instr_valid, bus.pc_sel} !== {2'b01, 2'd2}) begin
      n_fail++;
      $display("FAIL timeout_ack_wins: got err=%b valid=%b sel=%h expected 0/1/2",
               bus.fetch_err, bus.instr_valid, bus.pc_sel);
    end
  endtask
`else
  task automatic test_no_timeout();
    repeat (20) @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.fetch_err, bus.imem_addr} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL wait_forever: got req=%b err=%b addr=%h expected 1/0/0",
               bus.imem_req, bus.fetch_err, bus.imem_addr);
    end
  endtask
`endif

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.next_pc    = 32'h0;
    bus.stall      = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
